// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants used by fetch, decode and execute.
package cpu_pkg;

    localparam int XLEN       = 32;
    localparam int ADDR_W     = 32;
    localparam int INSN_BYTES = 4;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [ADDR_W-1:0] pc;
    } fetch_pkt;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets between instruction memory and decode.
// The head reads as all-zero while the FIFO is empty.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter type pkt_t = fetch_pkt,
    parameter int  DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  pkt_t                         push_pkt,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output pkt_t                         head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    pkt_t           mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           do_pop;

    assign do_pop = pop && (count != '0);

    // Pointer and occupancy bookkeeping; flush empties the FIFO and beats any pop.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage write port.
    // NOTE: storage is deliberately not reset; occupancy decides validity and the head is masked when empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_pkt;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        (push && !flush) |-> (count != CW'(DEPTH)));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC generation, credit-limited memory requests,
// in-order response buffering and redirect handling with in-flight discard.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH + 1);

    // Same layout as fetch_pkt, sized by this instance's address width.
    typedef struct packed {
        logic [XLEN-1:0]   instr;
        logic [ADDR_W-1:0] pc;
    } pkt_t;

    logic              running;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] resp_pc;
    logic [ADDR_W-1:0] target;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outstanding_nxt;
    logic [CW-1:0]     discard;
    logic [CW-1:0]     count;
    logic [CW:0]       in_use;
    logic              issue;
    logic              rsp;
    logic              push;
    pkt_t              push_pkt;
    pkt_t              head;

    assign target = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign in_use = {1'b0, count} + {1'b0, outstanding};

    // 'running' keeps the request line low while reset is held and until the first edge after it.
    assign imem_req  = running && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign imem_addr = pc;
    assign issue     = imem_req && imem_gnt;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp      = imem_rvalid && (outstanding != '0);
    assign push     = rsp && !redirect_valid && (discard == '0);
    assign push_pkt = '{instr: imem_rdata, pc: resp_pc};

    // In-flight count after this cycle's grant and response.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        outstanding_nxt = outstanding;
        case ({issue, rsp})
            2'b10:   outstanding_nxt = outstanding + CW'(1);
            2'b01:   outstanding_nxt = outstanding - CW'(1);
            default: outstanding_nxt = outstanding;
        endcase
    end

    // PC, response address, credit and discard tracking; redirect overrides everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running     <= 1'b0;
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            running     <= 1'b1;
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                pc      <= target;
                resp_pc <= target;
                // Pending discards are already part of 'outstanding', so every response
                // still in flight after this cycle belongs to a stale stream.
                discard <= outstanding - CW'(rsp);
            end else begin
                if (issue) pc <= pc + ADDR_W'(INSN_BYTES);
                if (rsp) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else               resp_pc <= resp_pc + ADDR_W'(INSN_BYTES);
                end
            end
        end
    end

    fetch_fifo #(
        .pkt_t (pkt_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_pkt (push_pkt),
        .pop      (instr_ready),
        .flush    (redirect_valid),
        .count    (count),
        .head     (head)
    );

    assign instr_valid = (count != '0);
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

    rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: an in-order memory model with random grants and
// latencies, a scoreboard of expected {instr, pc} fed by granted requests of the
// current fetch stream, and a monitor comparing every accepted instruction.
module tb_fetch_unit;

    localparam int              AW       = 32;
    localparam int              DEPTH    = 4;
    localparam logic [AW-1:0]   RESET_PC = 32'h0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [AW-1:0] instr_pc;

    typedef struct { logic [AW-1:0] addr; int epoch; int due; } mem_req_t;
    typedef struct { logic [31:0] instr; logic [AW-1:0] pc; } expect_t;

    mem_req_t      pending[$];
    expect_t       sb[$];
    int            cyc = 0;
    int            epoch = 0;
    int            checks = 0;
    int            failures = 0;
    int            pops = 0;
    int            first_grant_cyc = -1;
    int            first_valid_cyc = -1;
    int            lat_min = 1;
    int            lat_max = 1;
    int            gnt_pct = 100;
    logic [AW-1:0] next_fetch = RESET_PC;

    fetch_unit #(
        .ADDR_W   (AW),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_00FF;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Instruction memory: random grants, in-order responses once their latency has elapsed.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else begin
            imem_gnt = ($urandom_range(99) < gnt_pct);
            if (pending.size() > 0 && pending[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pending[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
        end
    end

    // Monitor: checks this cycle's outputs, then books the transfers that happen at the next edge.
    always @(negedge clk) begin : monitor
        int       sb_n;
        int       pend_n;
        int       lat;
        expect_t  e;
        mem_req_t m;
        if (rst_n) begin
            sb_n   = sb.size();
            pend_n = pending.size();
            check("instr_valid", instr_valid, sb_n != 0);
            check("imem_req_credit", imem_req, !redirect_valid && (sb_n + pend_n < DEPTH));
            if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (instr_valid && instr_ready && !redirect_valid && sb_n != 0) begin
                e = sb.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.instr);
                pops++;
            end
            if (imem_rvalid && pend_n > 0) begin
                m = pending.pop_front();
                if (!redirect_valid && m.epoch == epoch)
                    sb.push_back('{instr: mem_word(m.addr), pc: m.addr});
            end
            if (redirect_valid) begin
                sb.delete();
                epoch++;
                next_fetch = {redirect_pc[AW-1:2], 2'b00};
            end else if (imem_req && imem_gnt) begin
                check("imem_addr", imem_addr, next_fetch);
                lat = $urandom_range(lat_max, lat_min);
                pending.push_back('{addr: next_fetch, epoch: epoch, due: cyc + lat});
                next_fetch += 4;
                if (first_grant_cyc < 0) first_grant_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect(input logic [AW-1:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 64 && !instr_valid; i++) tick();
        if (!instr_valid) check("wait_valid_timeout", instr_valid, 1'b1);
    endtask

    task automatic mid_reset();
        redirect_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        pending.delete();
        sb.delete();
        epoch++;
        next_fetch = RESET_PC;
        #1;
        check("async_rst_valid", instr_valid, 1'b0);
        check("async_rst_instr", instr, 32'h0);
        check("async_rst_pc", instr_pc, 32'h0);
        check("async_rst_req", imem_req, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        tick();
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, RESET_PC);
    endtask

    initial begin
        int p0;
        rst_n          = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b0;

        #12;
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_req", imem_req, 1'b0);
        check("rst_addr", imem_addr, RESET_PC);
        @(negedge clk);
        #3;
        rst_n = 1'b1;

        // Decode stalled from the start: the FIFO fills and requests stop at DEPTH credits.
        repeat (10) tick();
        check("stall_req_low", imem_req, 1'b0);
        check("stall_buffered", sb.size(), DEPTH);
        check("stall_no_inflight", pending.size(), 0);
        check("stall_head_pc", instr_pc, RESET_PC);
        check("first_latency", first_valid_cyc - first_grant_cyc, 2);

        // Release: drain in order and sustain one instruction per cycle with L=1.
        instr_ready = 1'b1;
        p0 = pops;
        repeat (20) tick();
        check("throughput", pops - p0, 20);

        // L=3: redirect while three requests are in flight.
        lat_min = 3;
        lat_max = 3;
        redirect(32'h40);
        for (int i = 0; i < 50 && pending.size() != 3; i++) tick();
        check("three_outstanding", pending.size(), 3);
        redirect(32'h100);
        check("valid_after_redirect", instr_valid, 1'b0);
        wait_valid();
        check("l3_first_pc", instr_pc, 32'h100);
        check("l3_first_instr", instr, mem_word(32'h100));

        // Redirect in the same cycle as a response and a pop.
        lat_min = 2;
        lat_max = 2;
        for (int i = 0; i < 50 && !(imem_rvalid && instr_valid); i++) tick();
        check("coincident_setup", imem_rvalid && instr_valid, 1'b1);
        redirect(32'h180);
        wait_valid();
        check("coincident_pc", instr_pc, 32'h180);

        // Back-to-back redirects, then a misaligned target.
        redirect(32'h200);
        redirect(32'h300);
        check("b2b_valid_low", instr_valid, 1'b0);
        wait_valid();
        check("b2b_pc", instr_pc, 32'h300);
        repeat (6) tick();
        redirect(32'h203);
        wait_valid();
        check("misaligned_pc", instr_pc, 32'h200);

        // Random traffic with a reset in the middle of the stream.
        lat_min = 1;
        lat_max = 4;
        gnt_pct = 60;
        for (int i = 0; i < 600; i++) begin
            if (i == 300) mid_reset();
            instr_ready = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 4) begin
                redirect_valid = 1'b1;
                redirect_pc    = $urandom & 32'h0000_3FFF;
            end else begin
                redirect_valid = 1'b0;
            end
            tick();
        end
        redirect_valid = 1'b0;
        gnt_pct        = 100;
        instr_ready    = 1'b1;
        repeat (20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
